// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_pkg
//  Description : Shared definitions for the MEM-stage data-memory responder:
//                FSM state encoding, wait-counter width and the byte-lane
//                merge helper used to build write-first read data.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    // Responder FSM encoding (2-bit)
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE = 2'd0;
    localparam state_t ST_BUSY = 2'd1;
    localparam state_t ST_RESP = 2'd2;

    // Wait-state counter width; supports WAIT_CYCLES 0..15
    localparam int CNT_W = 4;

    // Replace the enabled byte lanes of old_word with those of new_word.
    function automatic logic [31:0] dmem_merge(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  lane_en
    );
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lane_en[i]) begin
                merged[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_bank.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_bank
//  Description : Single-port synchronous word RAM, 2**ADDR_WIDTH x 32, with
//                per-byte write enables and a registered, write-first read
//                port. Array contents are not reset; only the read register.
//  Ports       : clk    - clock, rising edge
//                rst    - asynchronous reset, active-low (read register only)
//                en     - access strobe (one cycle per access)
//                we     - byte-lane write enables, 0000 = read
//                addr   - word index
//                wdata  - lane-aligned write data
//                rd_clr - load zero into the read register instead of data
//                rdata  - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_bank
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    input  logic                  rd_clr,
    output logic [31:0]           rdata
);

    localparam int c_depth = 2 ** ADDR_WIDTH;

    logic [31:0] r_mem [c_depth];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    r_mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Write-first: the read register sees the merged post-write word.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rdata <= '0;
        end else if (en) begin
            r_rdata <= rd_clr ? 32'h0 : dmem_merge(r_mem[addr], wdata, we);
        end
    end

    assign rdata = r_rdata;

endmodule : dmem_bank
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_responder
//  Description : MEM-stage load/store responder. Accepts one request from
//                the pipeline, holds it for WAIT_CYCLES busy cycles while
//                stalling the pipeline, commits it to the RAM bank on the
//                edge entering RESP and presents registered read data.
//  Ports       : clk          - clock, rising edge
//                rst          - asynchronous reset, active-low
//                mem_en       - request valid, held while mem_stall=1
//                mem_wen      - byte write enables, 0000 = read
//                mem_addr     - byte address, bits [1:0] ignored
//                mem_wdata    - lane-aligned store data
//                mem_rdata    - load data, valid in RESP
//                mem_stall    - pipeline hold request
//                mem_addr_err - out-of-range address flag (DMEM_ERR_EN only)
//  Build macro : DMEM_ERR_EN - adds mem_addr_err; out-of-range accesses are
//                flagged, stores suppressed and read data forced to zero.
//                Without it, upper address bits alias.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 10,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_en,
    input  logic [3:0]  mem_wen,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_stall
`ifdef DMEM_ERR_EN
    ,
    output logic        mem_addr_err
`endif
);

    localparam logic [CNT_W-1:0] c_wait = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] c_one  = CNT_W'(1);

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [ADDR_WIDTH-1:0] r_idx;
    logic [3:0]            r_wen;
    logic [31:0]           r_wdata;

    logic                  w_accept;
    logic                  w_live;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_idx;
    logic [3:0]            w_wen;
    logic [31:0]           w_wdata;
    logic [3:0]            w_bank_we;
    logic                  w_bank_clr;
    logic                  w_unused_addr;

    assign w_accept = (r_state == ST_IDLE) && mem_en;

    // With zero wait states the commit edge is the accept edge, so the
    // bank must be fed from the live inputs while still in IDLE.
    assign w_live   = (r_state == ST_IDLE);
    assign w_idx    = w_live ? mem_addr[ADDR_WIDTH+1:2] : r_idx;
    assign w_wen    = w_live ? mem_wen   : r_wen;
    assign w_wdata  = w_live ? mem_wdata : r_wdata;

    // Commit exactly once, on the edge that enters RESP.
    assign w_commit = rst && (w_next == ST_RESP) && (r_state != ST_RESP);

    // Byte offset is never used; upper bits only matter for the error check.
    assign w_unused_addr = ^{mem_addr[31:ADDR_WIDTH+2], mem_addr[1:0]};

`ifdef DMEM_ERR_EN
    logic r_err;
    logic w_err;

    assign w_err      = w_live ? (|mem_addr[31:ADDR_WIDTH+2]) : r_err;
    assign w_bank_we  = w_err ? 4'b0000 : w_wen;
    assign w_bank_clr = w_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= |mem_addr[31:ADDR_WIDTH+2];
        end
    end

    assign mem_addr_err = (r_state == ST_RESP) && r_err;
`else
    assign w_bank_we  = w_wen;
    assign w_bank_clr = 1'b0;
`endif

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (mem_en) begin
                    w_next = (c_wait == '0) ? ST_RESP : ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (r_cnt <= c_one) begin
                    w_next = ST_RESP;
                end
            end
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        mem_stall = 1'b0;
        case (r_state)
            ST_IDLE: mem_stall = mem_en;
            ST_BUSY: mem_stall = 1'b1;
            default: mem_stall = 1'b0;
        endcase
        // Stall must drop the moment reset is applied, even with mem_en high.
        if (!rst) begin
            mem_stall = 1'b0;
        end
    end

    // ---------------- Wait counter and request capture ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_wen   <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_cnt   <= c_wait;
            r_idx   <= mem_addr[ADDR_WIDTH+1:2];
            r_wen   <= mem_wen;
            r_wdata <= mem_wdata;
        end else if (r_state == ST_BUSY) begin
            r_cnt   <= r_cnt - c_one;
        end
    end

    dmem_bank #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .en     (w_commit),
        .we     (w_bank_we),
        .addr   (w_idx),
        .wdata  (w_wdata),
        .rd_clr (w_bank_clr),
        .rdata  (mem_rdata)
    );

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_responder
//  Description : Scoreboard bench for dmem_responder. Two instances share
//                clock and reset: index 1 runs with WAIT_CYCLES=1, index 0
//                with WAIT_CYCLES=0. The driver pushes the expected response
//                for each request; a negedge monitor pops and compares read
//                data, stall length (and the error flag with DMEM_ERR_EN).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [1:0]        en;
    logic [1:0][3:0]   wen;
    logic [1:0][31:0]  addr;
    logic [1:0][31:0]  wdata;
    logic [31:0]       rdata1, rdata0;
    logic              stall1, stall0;
    logic [1:0]        stall_v;

    exp_t q1[$];
    exp_t q0[$];
    int   checks = 0;
    int   errors = 0;
    int   scnt[2];

    assign stall_v = {stall1, stall0};

    always #5 clk = ~clk;

`ifdef DMEM_ERR_EN
    logic       aerr1, aerr0;
    logic [1:0] aerr_v;
    assign aerr_v = {aerr1, aerr0};
`endif

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .mem_en    (en[1]),
        .mem_wen   (wen[1]),
        .mem_addr  (addr[1]),
        .mem_wdata (wdata[1]),
        .mem_rdata (rdata1),
        .mem_stall (stall1)
`ifdef DMEM_ERR_EN
        ,
        .mem_addr_err (aerr1)
`endif
    );

    dmem_responder #(.ADDR_WIDTH(10), .WAIT_CYCLES(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .mem_en    (en[0]),
        .mem_wen   (wen[0]),
        .mem_addr  (addr[0]),
        .mem_wdata (wdata[0]),
        .mem_rdata (rdata0),
        .mem_stall (stall0)
`ifdef DMEM_ERR_EN
        ,
        .mem_addr_err (aerr0)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", nm, act, exp);
        end
    endtask

    // ---------------- Monitor ----------------
    // In IDLE stall mirrors mem_en, so en=1 with stall=0 marks RESP.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            exp_t e;
            logic [31:0] act_rd;
            act_rd = (d == 1) ? rdata1 : rdata0;
            if (!rst) begin
                scnt[d] = 0;
            end else if (en[d] && stall_v[d]) begin
                scnt[d]++;
`ifdef DMEM_ERR_EN
                chk($sformatf("err_busy%0d", d), 32'(aerr_v[d]), 32'h0);
`endif
            end else if (en[d]) begin
                if ((d == 1 && q1.size() == 0) || (d == 0 && q0.size() == 0)) begin
                    chk($sformatf("unexpected_resp%0d", d), 32'h1, 32'h0);
                end else begin
                    e = (d == 1) ? q1.pop_front() : q0.pop_front();
                    chk($sformatf("rdata%0d", d), act_rd, e.rdata);
                    chk($sformatf("stall_len%0d", d), 32'(scnt[d]), (d == 1) ? 32'd2 : 32'd1);
`ifdef DMEM_ERR_EN
                    chk($sformatf("addr_err%0d", d), 32'(aerr_v[d]), 32'(e.err));
`endif
                end
                scnt[d] = 0;
            end
        end
    end

    // ---------------- Driver ----------------
    // Present a request and hold it until the RESP cycle has ended.
    task automatic issue(input int d, input logic [3:0] w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] exp_rd,
                         input logic exp_err);
        exp_t e;
        bit   done;
        e.rdata = exp_rd;
        e.err   = exp_err;
        if (d == 1) q1.push_back(e);
        else        q0.push_back(e);
        en[d]    = 1'b1;
        wen[d]   = w;
        addr[d]  = a;
        wdata[d] = wd;
        done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (!stall_v[d]) done = 1;
        end
        if (!done) chk($sformatf("resp_timeout%0d", d), 32'h1, 32'h0);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int d, input int n);
        en[d] = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        en    = 2'b11;
        wen   = '0;
        addr  = '0;
        wdata = '0;
        rst   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stall1", 32'(stall1), 32'h0);
        chk("rst_stall0", 32'(stall0), 32'h0);
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_rdata0", rdata0, 32'h0);
        en = 2'b00;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // WAIT_CYCLES=1 instance
        issue(1, 4'hF, 32'h0,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        issue(1, 4'h0, 32'h0,  32'h0,        32'hDEADBEEF, 1'b0);
        issue(1, 4'hF, 32'h10, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        issue(1, 4'h3, 32'h10, 32'h1234ABCD, 32'hFFFFABCD, 1'b0);
        issue(1, 4'h0, 32'h10, 32'h0,        32'hFFFFABCD, 1'b0);
        idle(1, 3);
        chk("rdata_hold", rdata1, 32'hFFFFABCD);
        issue(1, 4'hF, 32'h20, 32'h11111111, 32'h11111111, 1'b0);
        idle(1, 1);

        // Reset during BUSY of a full-word store: must be abandoned.
        en[1]    = 1'b1;
        wen[1]   = 4'hF;
        addr[1]  = 32'h20;
        wdata[1] = 32'hCAFEF00D;
        @(posedge clk);
        #1;
        chk("busy_stall", 32'(stall1), 32'h1);
        rst = 1'b0;
        #1;
        chk("abort_stall", 32'(stall1), 32'h0);
        chk("abort_rdata", rdata1, 32'h0);
        en[1] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        issue(1, 4'h0, 32'h20, 32'h0, 32'h11111111, 1'b0);

`ifdef DMEM_ERR_EN
        issue(1, 4'h1, 32'h1000, 32'h00000055, 32'h00000000, 1'b1);
        issue(1, 4'h0, 32'h0,    32'h0,        32'hDEADBEEF, 1'b0);
`else
        // 0x1000 aliases onto word 0 with a 10-bit index.
        issue(1, 4'h1, 32'h1000, 32'h00000055, 32'hDEADBE55, 1'b0);
        issue(1, 4'h0, 32'h0,    32'h0,        32'hDEADBE55, 1'b0);
`endif
        idle(1, 2);

        // WAIT_CYCLES=0 instance, mem_en held high throughout.
        issue(0, 4'hF, 32'h4, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b0);
        issue(0, 4'hF, 32'h8, 32'h0F0F0F0F, 32'h0F0F0F0F, 1'b0);
        issue(0, 4'h0, 32'h4, 32'h0,        32'hA5A5A5A5, 1'b0);
        issue(0, 4'h0, 32'h8, 32'h0,        32'h0F0F0F0F, 1'b0);
        issue(0, 4'hC, 32'h8, 32'hBEEF0000, 32'hBEEF0F0F, 1'b0);
        issue(0, 4'h0, 32'h8, 32'h0,        32'hBEEF0F0F, 1'b0);
        idle(0, 3);
        chk("rdata_hold0", rdata0, 32'hBEEF0F0F);

        chk("queues_empty", 32'(q0.size() + q1.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule : tb_dmem_responder
`default_nettype wire
